// File: rtl/dm_ctrl.sv
// Request/response data memory for the MEM stage: byte/half/word loads and stores, WAIT extra cycles per access.
// Optional macro DM_MISALIGN_TRAP_EN flags misaligned accesses with rsp_err instead of aligning them down.
module dm_ctrl #(
  parameter int DEPTH_WORDS = 128,
  parameter int ADDR_W      = $clog2(DEPTH_WORDS) + 2,
  parameter int WAIT        = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_type,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam logic [3:0] WAIT_L = 4'(WAIT);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  state_t              r_state, w_next;
  logic [3:0]          r_wcnt, w_wcnt_nxt;
  logic                r_we;
  logic [2:0]          r_type;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic [31:0]         r_rdata;
  logic                r_err;
  logic [31:0]         r_mem [DEPTH_WORDS];

  logic                w_acc, w_fire;
  logic                w_we;
  logic [2:0]          w_type;
  logic [ADDR_W-1:0]   w_addr;
  logic [31:0]         w_wdata;
  logic                w_is_h, w_is_b, w_is_w, w_sgn, w_err;
  logic [1:0]          w_lo;
  logic [ADDR_W-3:0]   w_idx;
  logic [3:0]          w_be;
  logic [31:0]         w_wd, w_word, w_ext, w_rd;
  logic [15:0]         w_h;
  logic [7:0]          w_b;

  assign req_ready = !rst && (r_state != S_BUSY);
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;
  assign w_acc     = req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_wcnt  <= '0;
      r_we    <= 1'b0;
      r_type  <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_next;
      r_wcnt  <= w_wcnt_nxt;
      if (w_acc) begin
        r_we    <= req_we;
        r_type  <= req_type;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end
    end
  end

  always_comb begin
    w_next     = r_state;
    w_wcnt_nxt = r_wcnt;
    case (r_state)
      S_IDLE, S_RESP: begin
        if (w_acc) begin
          if (WAIT == 0) begin
            w_next = S_RESP;
          end else begin
            w_next     = S_BUSY;
            w_wcnt_nxt = WAIT_L;
          end
        end else begin
          w_next = S_IDLE;
        end
      end
      S_BUSY: begin
        w_wcnt_nxt = r_wcnt - 4'd1;
        if (r_wcnt == 4'd1) w_next = S_RESP;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // The access executes on the edge that enters RESP; with no wait states that is
  // the accept edge itself, so the live request fields are used instead of the latch.
  assign w_fire  = (WAIT == 0) ? w_acc : (r_state == S_BUSY && r_wcnt == 4'd1);
  assign w_we    = (WAIT == 0) ? req_we    : r_we;
  assign w_type  = (WAIT == 0) ? req_type  : r_type;
  assign w_addr  = (WAIT == 0) ? req_addr  : r_addr;
  assign w_wdata = (WAIT == 0) ? req_wdata : r_wdata;

  assign w_is_h = (w_type == 3'd1) || (w_type == 3'd2);
  assign w_is_b = (w_type == 3'd3) || (w_type == 3'd4);
  assign w_is_w = !w_is_h && !w_is_b;
  assign w_sgn  = (w_type == 3'd1) || (w_type == 3'd3);
  assign w_idx  = w_addr[ADDR_W-1:2];

`ifdef DM_MISALIGN_TRAP_EN
  assign w_err = (w_is_w && (w_addr[1:0] != 2'b00)) || (w_is_h && w_addr[0]);
  assign w_lo  = w_addr[1:0];
`else
  assign w_err = 1'b0;
  assign w_lo  = w_is_w ? 2'b00 : (w_is_h ? {w_addr[1], 1'b0} : w_addr[1:0]);
`endif

  always_comb begin
    w_be = 4'b1111;
    w_wd = w_wdata;
    if (w_is_h) begin
      w_be = w_lo[1] ? 4'b1100 : 4'b0011;
      w_wd = {2{w_wdata[15:0]}};
    end else if (w_is_b) begin
      w_wd = {4{w_wdata[7:0]}};
      case (w_lo)
        2'd0:    w_be = 4'b0001;
        2'd1:    w_be = 4'b0010;
        2'd2:    w_be = 4'b0100;
        default: w_be = 4'b1000;
      endcase
    end
  end

  assign w_word = r_mem[w_idx];
  assign w_h    = w_lo[1] ? w_word[31:16] : w_word[15:0];

  always_comb begin
    case (w_lo)
      2'd0:    w_b = w_word[7:0];
      2'd1:    w_b = w_word[15:8];
      2'd2:    w_b = w_word[23:16];
      default: w_b = w_word[31:24];
    endcase
  end

  always_comb begin
    w_ext = w_word;
    if (w_is_h)      w_ext = w_sgn ? {{16{w_h[15]}}, w_h} : {16'h0, w_h};
    else if (w_is_b) w_ext = w_sgn ? {{24{w_b[7]}}, w_b} : {24'h0, w_b};
    w_rd = (w_we || w_err) ? 32'h0 : w_ext;
  end

  // Array is deliberately left without reset; reset on the commit edge suppresses the write.
  always_ff @(posedge clk) begin
    if (!rst && w_fire && w_we && !w_err) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wd[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else if (w_fire) begin
      r_rdata <= w_rd;
      r_err   <= w_err;
`ifdef DM_MISALIGN_TRAP_EN
      if (w_err) $display("dm misaligned 0x%h", w_addr);
`endif
    end
  end

endmodule

// File: tb/tb_dm_ctrl.sv
// Bench for dm_ctrl: WAIT=0 and WAIT=3 instances checked against a byte-array reference model.
module tb_dm_ctrl;
  localparam int AW = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_err = 0;
  int n_chk = 0;

  logic          rst_s [2];
  logic          rv    [2];
  logic          rwe   [2];
  logic [2:0]    rty   [2];
  logic [AW-1:0] rad   [2];
  logic [31:0]   rwd   [2];
  logic          rdy   [2];
  logic          rsv   [2];
  logic [31:0]   rrd   [2];
  logic          rer   [2];
  logic [7:0]    mm    [2][512];

  dm_ctrl #(.DEPTH_WORDS(128), .WAIT(0)) u_w0 (
    .clk(clk), .rst(rst_s[0]), .req_valid(rv[0]), .req_ready(rdy[0]), .req_we(rwe[0]),
    .req_type(rty[0]), .req_addr(rad[0]), .req_wdata(rwd[0]),
    .rsp_valid(rsv[0]), .rsp_rdata(rrd[0]), .rsp_err(rer[0]));

  dm_ctrl #(.DEPTH_WORDS(128), .WAIT(3)) u_w3 (
    .clk(clk), .rst(rst_s[1]), .req_valid(rv[1]), .req_ready(rdy[1]), .req_we(rwe[1]),
    .req_type(rty[1]), .req_addr(rad[1]), .req_wdata(rwd[1]),
    .rsp_valid(rsv[1]), .rsp_rdata(rrd[1]), .rsp_err(rer[1]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: memory as bytes, accesses as size-aligned byte runs with arithmetic extension.
  task automatic model(input int d, input logic we, input logic [2:0] t, input logic [AW-1:0] a,
                       input logic [31:0] wd, output logic [31:0] erd, output logic eerr);
    int sz;
    int base;
    logic [31:0] v;
    sz   = (t == 3'd1 || t == 3'd2) ? 2 : ((t == 3'd3 || t == 3'd4) ? 1 : 4);
    erd  = 32'h0;
    eerr = 1'b0;
`ifdef DM_MISALIGN_TRAP_EN
    if ((int'(a) % sz) != 0) begin
      eerr = 1'b1;
      return;
    end
`endif
    base = int'(a) - (int'(a) % sz);
    if (we) begin
      for (int i = 0; i < sz; i++) mm[d][base+i] = wd[8*i +: 8];
    end else begin
      v = 32'h0;
      for (int i = 0; i < sz; i++) v[8*i +: 8] = mm[d][base+i];
      if ((t == 3'd1 || t == 3'd3) && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8*sz));
      erd = v;
    end
  endtask

  task automatic acc(input int d, input logic we, input logic [2:0] t, input logic [AW-1:0] a,
                     input logic [31:0] wd, output logic [31:0] grd, output logic gerr);
    logic [31:0] erd;
    logic eerr;
    int g;
    int lat;
    int w;
    w = (d == 0) ? 0 : 3;
    model(d, we, t, a, wd, erd, eerr);
    rv[d] = 1'b1; rwe[d] = we; rty[d] = t; rad[d] = a; rwd[d] = wd;
    g = 0;
    while (!rdy[d] && g < 40) begin
      @(negedge clk);
      g++;
    end
    chk("accept_ready", {31'b0, rdy[d]}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    rv[d] = 1'b0; rwe[d] = 1'($urandom); rty[d] = 3'($urandom);
    rad[d] = AW'($urandom); rwd[d] = $urandom;
    lat = 1;
    while (!rsv[d] && lat < 40) begin
      chk("busy_ready", {31'b0, rdy[d]}, 32'd0);
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, 1 + w);
    grd  = rrd[d];
    gerr = rer[d];
    chk("rdata_model", grd, erd);
    chk("err_model", {31'b0, gerr}, {31'b0, eerr});
  endtask

  initial begin
    logic [31:0] rd;
    logic er;
    int t1;
    for (int d = 0; d < 2; d++) begin
      rst_s[d] = 1'b1; rv[d] = 1'b0; rwe[d] = 1'b0; rty[d] = 3'd0; rad[d] = '0; rwd[d] = '0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_ready", {31'b0, rdy[d]}, 32'd0);
      chk("rst_valid", {31'b0, rsv[d]}, 32'd0);
      chk("rst_rdata", rrd[d], 32'h0);
      chk("rst_err",   {31'b0, rer[d]}, 32'd0);
    end
    rst_s[0] = 1'b0; rst_s[1] = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) chk("post_rst_ready", {31'b0, rdy[d]}, 32'd1);

    for (int i = 0; i < 128; i++) begin
      acc(0, 1'b1, 3'd0, AW'(i*4), $urandom, rd, er);
      acc(1, 1'b1, 3'd0, AW'(i*4), $urandom, rd, er);
    end

    // word store then back-to-back load
    acc(0, 1'b1, 3'd0, 9'h010, 32'hDEADBEEF, rd, er);
    t1 = cyc;
    acc(0, 1'b0, 3'd0, 9'h010, 32'h0, rd, er);
    chk("b2b_gap", cyc - t1, 32'd1);
    chk("word_load", rd, 32'hDEADBEEF);

    // byte lanes
    acc(0, 1'b1, 3'd0, 9'h020, 32'h0, rd, er);
    acc(0, 1'b1, 3'd3, 9'h023, 32'h80, rd, er);
    acc(0, 1'b0, 3'd3, 9'h023, 32'h0, rd, er);
    chk("byte_signed", rd, 32'hFFFFFF80);
    acc(0, 1'b0, 3'd4, 9'h023, 32'h0, rd, er);
    chk("byte_unsigned", rd, 32'h00000080);
    acc(0, 1'b0, 3'd0, 9'h020, 32'h0, rd, er);
    chk("byte_word", rd, 32'h80000000);

    // halfword upper lane
    acc(0, 1'b1, 3'd0, 9'h030, 32'h11223344, rd, er);
    acc(0, 1'b1, 3'd1, 9'h032, 32'h0000A5A5, rd, er);
    acc(0, 1'b0, 3'd0, 9'h030, 32'h0, rd, er);
    chk("half_word", rd, 32'hA5A53344);
    acc(0, 1'b0, 3'd1, 9'h032, 32'h0, rd, er);
    chk("half_hi_signed", rd, 32'hFFFFA5A5);
    acc(0, 1'b0, 3'd1, 9'h030, 32'h0, rd, er);
    chk("half_lo_signed", rd, 32'h00003344);
    @(negedge clk);
    chk("pulse_one_cycle", {31'b0, rsv[0]}, 32'd0);

    // misaligned
    acc(0, 1'b1, 3'd0, 9'h040, 32'h12345678, rd, er);
    acc(0, 1'b1, 3'd0, 9'h041, 32'hCAFEF00D, rd, er);
`ifdef DM_MISALIGN_TRAP_EN
    chk("mis_store_err", {31'b0, er}, 32'd1);
    acc(0, 1'b0, 3'd0, 9'h040, 32'h0, rd, er);
    chk("mis_mem_kept", rd, 32'h12345678);
    acc(0, 1'b0, 3'd1, 9'h045, 32'h0, rd, er);
    chk("mis_load_err", {31'b0, er}, 32'd1);
    chk("mis_load_data", rd, 32'h0);
`else
    chk("mis_store_err", {31'b0, er}, 32'd0);
    acc(0, 1'b0, 3'd0, 9'h040, 32'h0, rd, er);
    chk("mis_aligned_wr", rd, 32'hCAFEF00D);
`endif

    // wait states, then reset during BUSY drops the store
    acc(1, 1'b1, 3'd0, 9'h040, 32'h12345678, rd, er);
    acc(1, 1'b0, 3'd0, 9'h040, 32'h0, rd, er);
    chk("w3_load", rd, 32'h12345678);
    @(negedge clk);
    rv[1] = 1'b1; rwe[1] = 1'b1; rty[1] = 3'd0; rad[1] = 9'h040; rwd[1] = 32'h55;
    chk("rst_seq_ready", {31'b0, rdy[1]}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    rv[1] = 1'b0;
    chk("rst_seq_busy", {31'b0, rdy[1]}, 32'd0);
    @(negedge clk);
    rst_s[1] = 1'b1;
    #1;
    chk("rst_hi_ready", {31'b0, rdy[1]}, 32'd0);
    @(negedge clk);
    rst_s[1] = 1'b0;
    chk("rst_clr_rdata", rrd[1], 32'h0);
    #1;
    chk("rst_lo_ready", {31'b0, rdy[1]}, 32'd1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("dropped_no_rsp", {31'b0, rsv[1]}, 32'd0);
    end
    acc(1, 1'b0, 3'd0, 9'h040, 32'h0, rd, er);
    chk("dropped_no_write", rd, 32'h12345678);

    // random traffic on both instances
    for (int k = 0; k < 80; k++) begin
      for (int d = 0; d < 2; d++) begin
        acc(d, 1'($urandom), 3'($urandom), AW'($urandom), $urandom, rd, er);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/dm_ctrl.md
# dm_ctrl

Parametrised data memory for the pipeline's MEM stage. It replaces the combinational-read array with a request/response memory that has a configurable number of wait states. Byte, halfword and word stores are lane-correct, using byte enables derived from the low address bits. Loads are sign- or zero-extended, and misaligned accesses can optionally be trapped. The MEM-stage hazard unit stalls on `req_ready`/`rsp_valid`.

## Interface
- `DEPTH_WORDS`, 128, number of 32-bit words; power of two, ≥ 4
- `ADDR_W`, `$clog2(DEPTH_WORDS)+2`, byte-address width
- `WAIT`, 0, extra cycles per access (0–15)
- `clk` input 1 — clock; one clock domain
- `rst` input 1 — synchronous, active-high reset
- `req_valid` input 1 — request present
- `req_ready` output 1 — block can accept a request this cycle
- `req_we` input 1 — 1 = store, 0 = load
- `req_type` input 3 — access type:
  - 000 word
  - 001 halfword signed
  - 010 halfword unsigned
  - 011 byte signed
  - 100 byte unsigned
  - 101–111 treated as word
- `req_addr` input `ADDR_W` — byte address
- `req_wdata` input 32 — store data, right-aligned (byte in [7:0], halfword in [15:0])
- `rsp_valid` output 1 — one-cycle pulse that completes the accepted access
- `rsp_rdata` output 32 — extended load data; 0 for stores and errors
- `rsp_err` output 1 — misaligned access, qualified by `rsp_valid`

## Operation
- **Handshake.** A request is accepted when `req_valid && req_ready` is high at a rising edge. The request fields are latched at that edge and need not be held afterwards.
- **FSM states.**
  - IDLE: `req_ready`=1. On accept, go to RESP if `WAIT`==0; otherwise load `wcnt`=`WAIT` and go to BUSY.
  - BUSY: `req_ready`=0. Decrement `wcnt` each cycle; when `wcnt`==1, go to RESP.
  - RESP: `rsp_valid`=1 and `req_ready`=1. On accept, proceed exactly as from IDLE; otherwise go to IDLE.
- **Array access.** The array update and the read sampling both happen on the edge that enters RESP. `rsp_rdata`/`rsp_err` are registered there.
- **Store byte enables.**
  - Word: 1111.
  - Halfword: 0011 when `addr[1]`=0, 1100 when `addr[1]`=1.
  - Byte: one-hot on `addr[1:0]`.
  - Write data is replicated across lanes.
  - Lanes without an enable keep their value.
- **Load lane selection.**
  - Halfword uses word[15:0] or word[31:16] by `addr[1]`.
  - Byte uses the lane given by `addr[1:0]`.
  - Signed types replicate the lane MSB; unsigned types zero-fill.
- **Word index.** `addr[ADDR_W-1:2]`; the whole address space is in range by construction.
- **Ordering.** A load accepted in the RESP cycle of a prior store returns the stored data, because the store committed at the previous edge.
- **Array contents.** Not reset and not initialised by the block.

## Timing
- Reset values: state=IDLE, `wcnt`=0, `req_ready`=0 while `rst` is high and 1 in the first cycle after, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0.
- Latency: `rsp_valid` is asserted `1+WAIT` cycles after the accept edge.
- Throughput: one access every `1+WAIT` cycles; with `WAIT`=0, back-to-back accesses complete at 1/cycle.
- No response backpressure: the consumer must sample during the `rsp_valid` cycle.
- `rst` asserted in BUSY: the pending access is dropped, with no array write and no response. `rst` asserted on the RESP-entry edge: reset wins and no write occurs.
- `req_valid` while `req_ready`=0 is ignored; the requester must hold it.

## Configuration
- Macro `DM_MISALIGN_TRAP_EN`.
- **Defined:**
  - Misaligned accesses are a word access with `addr[1:0]`≠0, or a halfword with `addr[0]`=1.
  - A misaligned access completes with normal latency, `rsp_err`=1, `rsp_rdata`=0 and no array write.
  - The block emits `$display("dm misaligned 0x%h", addr)`.
- **Undefined:**
  - Misaligned low bits are ignored: word forces `addr[1:0]`=0, halfword forces `addr[0]`=0.
  - `rsp_err` is tied to 0.

## Test plan
- **Word store/load.** Reset, `WAIT`=0. Store word 0xDEADBEEF to 0x010, then load word from 0x010 back-to-back. Expect `rsp_valid` on consecutive cycles and the load to return 0xDEADBEEF.
- **Byte lanes.** Word 0x00000000 at 0x020. Store byte 0x80 to 0x023. Load byte signed at 0x023 → 0xFFFFFF80; unsigned → 0x00000080; word → 0x80000000.
- **Halfword upper lane.** Word 0x11223344 at 0x030. Store halfword 0xA5A5 to 0x032. Load word → 0xA5A53344. Load halfword signed at 0x032 → 0xFFFFA5A5; at 0x030 → 0x00003344.
- **Wait states and reset.** `WAIT`=3. A load accepted at cycle t gives `rsp_valid` at t+4, with `req_ready`=0 during t+1..t+3. Then, with 0x12345678 at 0x040, a store of 0x55 issued to 0x040 and `rst` pulsed at t+2 gives no response and the word stays 0x12345678.
- **Misaligned, macro defined.** Store word to 0x041 → `rsp_err`=1, memory unchanged; halfword load at 0x045 → `rsp_err`=1, `rsp_rdata`=0.
- **Misaligned, macro undefined.** Store word 0xCAFEF00D to 0x041 → written at 0x040 with `rsp_err`=0.
